// File: rtl/mem_initiator_if.sv
// Bundles the command, write-data, read-data, response and memory-port signals of mem_initiator.
// The master modport is the initiator's view; the slave modport is the host/memory side.
interface mem_initiator_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid_in;
    logic                  cmd_ready_out;
    logic                  cmd_write_in;
    logic [DATA_WIDTH-1:0] cmd_addr_in;
    logic [7:0]            cmd_len_in;

    logic                  wr_valid_in;
    logic                  wr_ready_out;
    logic [DATA_WIDTH-1:0] wr_data_in;

    logic                  rd_valid_out;
    logic [DATA_WIDTH-1:0] rd_data_out;

    logic                  resp_valid_out;
    logic                  resp_err_out;

    logic                  mem_enable_out;
    logic                  mem_write_out;
    logic                  mem_ready_in;
    logic [DATA_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport master (
        input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_len_in,
        input  wr_valid_in, wr_data_in,
        input  mem_ready_in, mem_data_in,
        output cmd_ready_out, wr_ready_out,
        output rd_valid_out, rd_data_out,
        output resp_valid_out, resp_err_out,
        output mem_enable_out, mem_write_out, mem_addr_out, mem_data_out
    );

    modport slave (
        output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_len_in,
        output wr_valid_in, wr_data_in,
        output mem_ready_in, mem_data_in,
        input  cmd_ready_out, wr_ready_out,
        input  rd_valid_out, rd_data_out,
        input  resp_valid_out, resp_err_out,
        input  mem_enable_out, mem_write_out, mem_addr_out, mem_data_out
    );
endinterface

// File: rtl/mem_initiator.sv
// Burst memory initiator: turns one read/write burst command into per-beat single-cycle memory accesses.
// Optional WAIT-state timeout abort is built in when MEM_INITIATOR_TIMEOUT_EN is defined.
module mem_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    mem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            beats_q, beats_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  mem_ready;
    logic                  mem_enable;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic                  resp_valid;

`ifdef MEM_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             timed_out;

    // Last WAIT cycle without ready is cycle number TIMEOUT_CYCLES.
    assign timed_out = (32'(wait_cnt_q) == 32'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // An X or Z ready fails the if-test, so only a real 1 is taken as ready.
    always_comb begin
        mem_ready = 1'b0;
        if (bus.mem_ready_in) mem_ready = 1'b1;
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        rd_data_d  = rd_data_q;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_data   = '0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        resp_valid = 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
        wait_cnt_d = '0;
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_in) begin
                    is_write_d = bus.cmd_write_in;
                    addr_d     = bus.cmd_addr_in;
                    beats_d    = bus.cmd_len_in;
                    state_d    = ISSUE;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end

            ISSUE: begin
                if (!is_write_q) begin
                    mem_enable = 1'b1;
                    state_d    = WAIT;
                end else begin
                    wr_ready = 1'b1;
                    if (bus.wr_valid_in) begin
                        mem_enable = 1'b1;
                        mem_write  = 1'b1;
                        mem_data   = bus.wr_data_in;
                        state_d    = WAIT;
                    end
                end
            end

            WAIT: begin
                if (mem_ready) begin
                    if (!is_write_q) begin
                        rd_valid  = 1'b1;
                        rd_data_d = bus.mem_data_in;
                    end
                    if (beats_q != 8'd0) begin
                        beats_d = beats_q - 8'd1;
                        addr_d  = addr_q + DATA_WIDTH'(1);
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                    end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            // NOTE: the read-data holding register is reset too, because rd_data_out must read 0 in reset.
            rd_data_q  <= '0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            rd_data_q  <= rd_data_d;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // cmd_ready is gated by reset so it only rises once reset is released.
    assign bus.cmd_ready_out  = (state_q == IDLE) && rst_n_in;
    assign bus.wr_ready_out   = wr_ready;
    assign bus.rd_valid_out   = rd_valid;
    assign bus.rd_data_out    = rd_valid ? bus.mem_data_in : rd_data_q;
    assign bus.resp_valid_out = resp_valid;
    assign bus.mem_enable_out = mem_enable;
    assign bus.mem_write_out  = mem_write;
    assign bus.mem_addr_out   = addr_q;
    assign bus.mem_data_out   = mem_data;

`ifdef MEM_INITIATOR_TIMEOUT_EN
    assign bus.resp_err_out = resp_valid && err_q;
`else
    assign bus.resp_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator; inputs change on the falling edge, outputs are checked 1 ns later.
module tb_mem_initiator;

    localparam int DW = 32;

    // Expected control vector: {cmd_ready, wr_ready, mem_enable, mem_write, rd_valid, resp_valid, resp_err}
    localparam logic [6:0] C_OFF      = 7'b0000000;
    localparam logic [6:0] C_IDLE     = 7'b1000000;
    localparam logic [6:0] C_ISSUE_RD = 7'b0010000;
    localparam logic [6:0] C_WR_STALL = 7'b0100000;
    localparam logic [6:0] C_ISSUE_WR = 7'b0111000;
    localparam logic [6:0] C_WAIT     = 7'b0000000;
    localparam logic [6:0] C_WAIT_RD  = 7'b0000100;
    localparam logic [6:0] C_RESP     = 7'b0000010;
    localparam logic [6:0] C_RESP_ERR = 7'b0000011;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk_in = ~clk_in;

    mem_initiator_if #(.DATA_WIDTH(DW)) bus ();

    mem_initiator #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    logic [6:0] ctl;
    assign ctl = {bus.cmd_ready_out, bus.wr_ready_out, bus.mem_enable_out, bus.mem_write_out,
                  bus.rd_valid_out, bus.resp_valid_out, bus.resp_err_out};

    task automatic next_cycle();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (ctl !== C_OFF) begin
            miscompares++;
            $display("FAIL reset_ctl got=%b want=%b", ctl, C_OFF);
        end
        vectors++;
        if (bus.mem_addr_out !== 32'h0 || bus.rd_data_out !== 32'h0 || bus.mem_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data addr=%h rd=%h wd=%h want all 0",
                     bus.mem_addr_out, bus.rd_data_out, bus.mem_data_out);
        end
        next_cycle();
        rst_n_in = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("FAIL reset_release_ctl got=%b want=%b", ctl, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        bus.cmd_valid_in = 1'b1;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = 32'h10;
        bus.cmd_len_in   = 8'd0;
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("FAIL rd1_accept got=%b want=%b", ctl, C_IDLE);
        end
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== 32'h10) begin
            miscompares++;
            $display("FAIL rd1_issue ctl=%b addr=%h want %b/00000010", ctl, bus.mem_addr_out, C_ISSUE_RD);
        end
        next_cycle();
        bus.mem_data_in = 32'hDEADBEEF;
        #1;
        vectors++;
        if (ctl !== C_WAIT_RD || bus.rd_data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd1_beat ctl=%b data=%h want %b/deadbeef", ctl, bus.rd_data_out, C_WAIT_RD);
        end
        next_cycle();
        bus.mem_data_in = 32'h12345678;
        #1;
        vectors++;
        if (ctl !== C_RESP || bus.rd_data_out !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd1_resp ctl=%b held=%h want %b/deadbeef", ctl, bus.rd_data_out, C_RESP);
        end
        next_cycle();
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("FAIL rd1_idle got=%b want=%b", ctl, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_write_stall();
        bus.cmd_valid_in = 1'b1;
        bus.cmd_write_in = 1'b1;
        bus.cmd_addr_in  = 32'h20;
        bus.cmd_len_in   = 8'd3;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int s = 0; s < 2; s++) begin
                    bus.wr_valid_in = 1'b0;
                    #1;
                    vectors++;
                    if (ctl !== C_WR_STALL) begin
                        miscompares++;
                        $display("FAIL wr_stall%0d got=%b want=%b", s, ctl, C_WR_STALL);
                    end
                    next_cycle();
                end
            end
            bus.wr_valid_in = 1'b1;
            bus.wr_data_in  = 32'hA5A5_0000 + 32'(b);
            #1;
            vectors++;
            if (ctl !== C_ISSUE_WR || bus.mem_addr_out !== 32'h20 + 32'(b)
                || bus.mem_data_out !== 32'hA5A5_0000 + 32'(b)) begin
                miscompares++;
                $display("FAIL wr_beat%0d ctl=%b addr=%h data=%h want %b/%h/%h", b, ctl,
                         bus.mem_addr_out, bus.mem_data_out, C_ISSUE_WR, 32'h20 + 32'(b), 32'hA5A5_0000 + 32'(b));
            end
            next_cycle();
            bus.wr_valid_in = 1'b0;
            #1;
            vectors++;
            if (ctl !== C_WAIT) begin
                miscompares++;
                $display("FAIL wr_wait%0d got=%b want=%b", b, ctl, C_WAIT);
            end
            next_cycle();
        end
        #1;
        vectors++;
        if (ctl !== C_RESP) begin
            miscompares++;
            $display("FAIL wr_resp got=%b want=%b", ctl, C_RESP);
        end
        next_cycle();
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("FAIL wr_idle got=%b want=%b", ctl, C_IDLE);
        end
        bus.cmd_write_in = 1'b0;
        next_cycle();
    endtask

    task automatic test_wrap_read();
        logic [DW-1:0] exp_addr [2];
        exp_addr[0] = 32'hFFFF_FFFF;
        exp_addr[1] = 32'h0000_0000;
        bus.cmd_valid_in = 1'b1;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = 32'hFFFF_FFFF;
        bus.cmd_len_in   = 8'd1;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            vectors++;
            if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== exp_addr[b]) begin
                miscompares++;
                $display("FAIL wrap_issue%0d ctl=%b addr=%h want %b/%h", b, ctl, bus.mem_addr_out,
                         C_ISSUE_RD, exp_addr[b]);
            end
            next_cycle();
            bus.mem_data_in = 32'h0BAD_0000 + 32'(b);
            #1;
            vectors++;
            if (ctl !== C_WAIT_RD || bus.rd_data_out !== 32'h0BAD_0000 + 32'(b)) begin
                miscompares++;
                $display("FAIL wrap_beat%0d ctl=%b data=%h want %b/%h", b, ctl, bus.rd_data_out,
                         C_WAIT_RD, 32'h0BAD_0000 + 32'(b));
            end
            next_cycle();
        end
        #1;
        vectors++;
        if (ctl !== C_RESP) begin
            miscompares++;
            $display("FAIL wrap_resp got=%b want=%b", ctl, C_RESP);
        end
        next_cycle();
    endtask

`ifdef MEM_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'h50;
        bus.cmd_len_in   = 8'd2;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== 32'h50) begin
            miscompares++;
            $display("FAIL to_issue ctl=%b addr=%h want %b/00000050", ctl, bus.mem_addr_out, C_ISSUE_RD);
        end
        next_cycle();
        bus.mem_ready_in = 1'bz;
        for (int w = 0; w < 4; w++) begin
            #1;
            vectors++;
            if (ctl !== C_WAIT) begin
                miscompares++;
                $display("FAIL to_wait%0d got=%b want=%b", w, ctl, C_WAIT);
            end
            next_cycle();
        end
        bus.mem_ready_in = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_RESP_ERR) begin
            miscompares++;
            $display("FAIL to_resp got=%b want=%b", ctl, C_RESP_ERR);
        end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (ctl !== C_IDLE) begin
                miscompares++;
                $display("FAIL to_idle%0d got=%b want=%b", i, ctl, C_IDLE);
            end
            next_cycle();
        end
    endtask
`else
    task automatic test_wait_forever();
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'h40;
        bus.cmd_len_in   = 8'd0;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        next_cycle();
        for (int w = 0; w < 10; w++) begin
            bus.mem_ready_in = (w % 2 == 0) ? 1'b0 : 1'bz;
            #1;
            vectors++;
            if (ctl !== C_WAIT) begin
                miscompares++;
                $display("FAIL hold_wait%0d got=%b want=%b", w, ctl, C_WAIT);
            end
            next_cycle();
        end
        bus.mem_ready_in = 1'b1;
        bus.mem_data_in  = 32'h4444_4444;
        #1;
        vectors++;
        if (ctl !== C_WAIT_RD || bus.rd_data_out !== 32'h4444_4444) begin
            miscompares++;
            $display("FAIL hold_beat ctl=%b data=%h want %b/44444444", ctl, bus.rd_data_out, C_WAIT_RD);
        end
        next_cycle();
        #1;
        vectors++;
        if (ctl !== C_RESP) begin
            miscompares++;
            $display("FAIL hold_resp got=%b want=%b", ctl, C_RESP);
        end
        next_cycle();
    endtask
`endif

    task automatic test_reset_mid_burst();
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'h100;
        bus.cmd_len_in   = 8'd7;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            bus.mem_data_in = 32'h5500_0000 + 32'(b);
            #1;
            vectors++;
            if (ctl !== C_WAIT_RD || bus.rd_data_out !== 32'h5500_0000 + 32'(b)) begin
                miscompares++;
                $display("FAIL rst_beat%0d ctl=%b data=%h want %b/%h", b, ctl, bus.rd_data_out,
                         C_WAIT_RD, 32'h5500_0000 + 32'(b));
            end
            next_cycle();
        end
        #1;
        vectors++;
        if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== 32'h102) begin
            miscompares++;
            $display("FAIL rst_beat3_issue ctl=%b addr=%h want %b/00000102", ctl, bus.mem_addr_out, C_ISSUE_RD);
        end
        rst_n_in = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_OFF || bus.mem_addr_out !== 32'h0 || bus.rd_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_async ctl=%b addr=%h rd=%h want %b/0/0", ctl, bus.mem_addr_out,
                     bus.rd_data_out, C_OFF);
        end
        next_cycle();
        rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (ctl !== C_IDLE) begin
                miscompares++;
                $display("FAIL rst_after%0d got=%b want=%b", i, ctl, C_IDLE);
            end
            next_cycle();
        end
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'h200;
        bus.cmd_len_in   = 8'd0;
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== 32'h200) begin
            miscompares++;
            $display("FAIL rst_next_issue ctl=%b addr=%h want %b/00000200", ctl, bus.mem_addr_out, C_ISSUE_RD);
        end
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if (ctl !== C_RESP) begin
            miscompares++;
            $display("FAIL rst_next_resp got=%b want=%b", ctl, C_RESP);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seq [5];
        exp_seq[0] = C_ISSUE_RD;
        exp_seq[1] = C_WAIT_RD;
        exp_seq[2] = C_ISSUE_RD;
        exp_seq[3] = C_WAIT_RD;
        exp_seq[4] = C_RESP;
        bus.cmd_valid_in = 1'b1;
        bus.cmd_addr_in  = 32'h300;
        bus.cmd_len_in   = 8'd1;
        next_cycle();
        bus.cmd_addr_in  = 32'h400;
        bus.cmd_len_in   = 8'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (ctl !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL b2b_busy%0d got=%b want=%b", c, ctl, exp_seq[c]);
            end
            next_cycle();
        end
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("FAIL b2b_idle got=%b want=%b", ctl, C_IDLE);
        end
        next_cycle();
        bus.cmd_valid_in = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_ISSUE_RD || bus.mem_addr_out !== 32'h400) begin
            miscompares++;
            $display("FAIL b2b_second ctl=%b addr=%h want %b/00000400", ctl, bus.mem_addr_out, C_ISSUE_RD);
        end
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        rst_n_in         = 1'b0;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = '0;
        bus.cmd_len_in   = '0;
        bus.wr_valid_in  = 1'b0;
        bus.wr_data_in   = '0;
        bus.mem_ready_in = 1'b1;
        bus.mem_data_in  = '0;

        test_reset();
        test_single_read();
        test_write_stall();
        test_wrap_read();
`ifdef MEM_INITIATOR_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        test_reset_mid_burst();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the address and data paths.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the WAIT-state cycles allowed before abort when the timeout feature is built in.
REQ-003 Ports SHALL be:
  clk_in  in  1  single clock, rising edge
  rst_n_in  in  1  asynchronous active-low reset
  cmd_valid_in  in  1  command offered
  cmd_ready_out  out  1  command accepted when high with cmd_valid_in
  cmd_write_in  in  1  1 = write burst, 0 = read burst
  cmd_addr_in  in  DATA_WIDTH  first word address
  cmd_len_in  in  8  beats minus one (0..255 = 1..256 beats)
  wr_valid_in  in  1  write beat data offered
  wr_ready_out  out  1  write beat data consumed when high with wr_valid_in
  wr_data_in  in  DATA_WIDTH  write beat data
  rd_valid_out  out  1  one-cycle pulse per read beat
  rd_data_out  out  DATA_WIDTH  read beat data, valid with rd_valid_out
  resp_valid_out  out  1  one-cycle pulse at burst end
  resp_err_out  out  1  burst aborted by timeout, valid with resp_valid_out
  mem_enable_out  out  1  memory port enable
  mem_write_out  out  1  memory port write
  mem_ready_in  in  1  memory ready; only a sampled value of exactly 1 counts as ready (0, X, Z = not ready)
  mem_addr_out  out  DATA_WIDTH  memory address
  mem_data_out  out  DATA_WIDTH  memory write data
  mem_data_in  in  DATA_WIDTH  memory read data

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: cmd_ready_out=1; on cmd_valid_in the command, address and beat counter SHALL be latched and the FSM SHALL go to ISSUE.
REQ-006 cmd_ready_out SHALL be 0 in every state except IDLE; commands offered while busy SHALL be held off, never dropped.
REQ-007 ISSUE, read: mem_enable_out=1, mem_write_out=0 for exactly one cycle, then WAIT.
REQ-008 ISSUE, write: wr_ready_out=1; FSM SHALL stay in ISSUE with mem_enable_out=0 until wr_valid_in; on that cycle mem_enable_out=1, mem_write_out=1, mem_data_out=wr_data_in, then WAIT.
REQ-009 mem_enable_out SHALL be 0 in IDLE, WAIT and RESP, giving one enable pulse per beat.
REQ-010 WAIT: when mem_ready_in is 1, a read beat SHALL drive rd_valid_out=1 and rd_data_out=mem_data_in in the same cycle.
REQ-011 WAIT exit on ready: if beats remain, address +1 (mod 2^DATA_WIDTH) and go to ISSUE; otherwise go to RESP.
REQ-012 Minimum cost SHALL be 2 cycles per beat (ISSUE+WAIT) plus 1 RESP cycle.
REQ-013 RESP: resp_valid_out=1 for one cycle with resp_err_out, then IDLE.
REQ-014 Address 2^DATA_WIDTH-1 SHALL wrap to 0 mid-burst, with no error.
REQ-015 rd_data_out SHALL hold its last value between pulses.

Reset
REQ-016 While rst_n_in=0, asynchronously: FSM=IDLE, counters=0, every output 0 except cmd_ready_out, which SHALL be 1 only after rst_n_in deasserts.
REQ-017 Reset mid-burst SHALL abort with no resp_valid_out and no further memory access; remaining beats are lost.

Configuration
REQ-018 Macro MEM_INITIATOR_TIMEOUT_EN defined: WAIT SHALL count cycles; after TIMEOUT_CYCLES cycles without ready, the burst SHALL abort to RESP with resp_err_out=1 and no further beats are issued.
REQ-019 Macro MEM_INITIATOR_TIMEOUT_EN undefined: no counter; WAIT SHALL wait indefinitely; resp_err_out SHALL be constant 0.

Verification
REQ-020 Read, addr 0x10, len 0, memory returns 0xDEADBEEF -> one enable pulse at 0x10, rd_valid_out once with 0xDEADBEEF, resp_valid_out with err=0 three cycles after acceptance.
REQ-021 Write, addr 0x20, len 3, wr_valid_in stalled 2 cycles before beat 2 -> four writes to 0x20..0x23 in order, ISSUE held during the stall, one resp.
REQ-022 Read, addr 0xFFFFFFFF, len 1 -> accesses at 0xFFFFFFFF then 0x00000000.
REQ-023 MEM_INITIATOR_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready_in held Z -> resp_err_out=1 after 4 WAIT cycles, no second enable pulse.
REQ-024 rst_n_in pulsed low during beat 3 of an 8-beat read -> all outputs 0 immediately, no resp, next command accepted normally.
REQ-025 cmd_valid_in held high through a 2-beat burst -> second command accepted only in the IDLE cycle after resp_valid_out.
